// File: rtl/call_stack_ctl.sv
// call_stack_ctl: return-address stack with per-branch checkpoints for mispredict repair.
// Define CALLSTACK_CKPT_EN to build the checkpoint table; otherwise restore just clears the stack.
module call_stack_ctl #(
  parameter int DEPTH = 16,
  parameter int IP_WIDTH = 48,
  parameter int NCKPT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_en,
  input  logic [IP_WIDTH-1:0]      push_addr,
  input  logic                     pop_en,
  output logic                     pred_valid,
  output logic [IP_WIDTH-1:0]      pred_addr,
  input  logic                     ckpt_take,
  output logic [$clog2(NCKPT)-1:0] ckpt_id,
  output logic                     ckpt_full,
  input  logic                     ckpt_free,
  input  logic                     restore_en,
  input  logic [$clog2(NCKPT)-1:0] restore_id,
  output logic                     busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CNW = PW + 1;
  localparam logic [PW:0] CNT_MAX = CNW'(DEPTH);
  localparam logic [PW:0] CNT_ONE = CNW'(1);
  typedef enum logic {IDLE, RESTORE} state_e;
  state_e state_q, state_d;
  logic [IP_WIDTH-1:0] stk_q [DEPTH];
  logic [PW-1:0] tos_q, tos_d, r_tos, wr_addr;
  logic [PW:0] cnt_q, cnt_d, r_cnt;
  logic [IP_WIDTH-1:0] r_top, wr_data, pred_addr_q, pred_addr_d;
  logic pred_valid_q, pred_valid_d, act, do_push, do_pop, nonempty, wr_en, r_we;

`ifdef CALLSTACK_CKPT_EN
  localparam int CW = $clog2(NCKPT);
  localparam int LW = CW + 1;
  localparam logic [CW:0] LIVE_MAX = LW'(NCKPT);
  logic [PW-1:0] ck_tos_q [NCKPT];
  logic [PW:0] ck_cnt_q [NCKPT];
  logic [IP_WIDTH-1:0] ck_top_q [NCKPT];
  logic [CW-1:0] alloc_q, alloc_d, rel_q, rel_d;
  logic [CW:0] live_q, live_d;
  logic take_ok, free_ok;
  always_comb begin
    take_ok = act && ckpt_take && live_q != LIVE_MAX;
    free_ok = ckpt_free && live_q != '0;
    rel_d = rel_q + CW'(free_ok);
    alloc_d = restore_en ? restore_id + 1'b1 : alloc_q + CW'(take_ok);
    // restoring keeps every slot from the release pointer up to and including restore_id
    live_d = restore_en ? {1'b0, restore_id - rel_q} + LW'(1) - LW'(free_ok)
                        : live_q + LW'(take_ok) - LW'(free_ok);
    r_tos = ck_tos_q[restore_id];
    r_cnt = ck_cnt_q[restore_id];
    r_top = ck_top_q[restore_id];
    r_we = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      alloc_q <= '0;
      rel_q <= '0;
      live_q <= '0;
    end else begin
      alloc_q <= alloc_d;
      rel_q <= rel_d;
      live_q <= live_d;
    end
  end
  always_ff @(posedge clk) begin
    if (take_ok) begin
      ck_tos_q[alloc_q] <= tos_q;
      ck_cnt_q[alloc_q] <= cnt_q;
      ck_top_q[alloc_q] <= stk_q[tos_q];
    end
  end
  assign ckpt_id = alloc_q;
  assign ckpt_full = live_q == LIVE_MAX;
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{ckpt_take, ckpt_free, restore_id};
  assign r_tos = '1;
  assign r_cnt = '0;
  assign r_top = '0;
  assign r_we = 1'b0;
  assign ckpt_id = '0;
  assign ckpt_full = 1'b0;
`endif

  always_comb begin
    act = state_q == IDLE && !restore_en;
    do_push = act && push_en;
    do_pop = act && pop_en;
    nonempty = cnt_q != '0;
    state_d = restore_en ? RESTORE : IDLE;
    tos_d = restore_en ? r_tos
          : do_push && !do_pop ? tos_q + 1'b1
          : do_pop && !do_push && nonempty ? tos_q - 1'b1 : tos_q;
    cnt_d = restore_en ? r_cnt
          : do_push && do_pop ? (nonempty ? cnt_q : CNT_ONE)
          : do_push ? (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1)
          : do_pop && nonempty ? cnt_q - 1'b1 : cnt_q;
    pred_valid_d = do_pop && nonempty;
    pred_addr_d = do_pop && (do_push || nonempty) ? stk_q[tos_q] : pred_addr_q;
    // restore rewrites the saved top in case a push replaced it after a pop
    wr_en = restore_en ? r_we : do_push;
    wr_addr = restore_en ? r_tos : do_pop ? tos_q : tos_q + 1'b1;
    wr_data = restore_en ? r_top : push_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tos_q <= '1;
      cnt_q <= '0;
      pred_valid_q <= 1'b0;
      pred_addr_q <= '0;
    end else begin
      state_q <= state_d;
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      pred_valid_q <= pred_valid_d;
      pred_addr_q <= pred_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) stk_q[wr_addr] <= wr_data;
  end

  assign pred_valid = pred_valid_q;
  assign pred_addr = pred_addr_q;
  assign busy = state_q == RESTORE;
endmodule

// File: tb/tb_call_stack_ctl.sv
// tb_call_stack_ctl: directed plan scenarios plus random traffic against a queue-based model.
module tb_call_stack_ctl;
  localparam int DEPTH = 16;
  localparam int W = 48;
  localparam int N = 8;
  localparam int CW = 3;
`ifdef CALLSTACK_CKPT_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, push_en = 1'b0, pop_en = 1'b0;
  logic ckpt_take = 1'b0, ckpt_free = 1'b0, restore_en = 1'b0;
  logic [W-1:0] push_addr = '0;
  logic [CW-1:0] restore_id = '0;
  logic pred_valid, ckpt_full, busy;
  logic [W-1:0] pred_addr;
  logic [CW-1:0] ckpt_id;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  call_stack_ctl #(.DEPTH(DEPTH), .IP_WIDTH(W), .NCKPT(N)) dut (
    .clk(clk), .rst(rst), .push_en(push_en), .push_addr(push_addr), .pop_en(pop_en),
    .pred_valid(pred_valid), .pred_addr(pred_addr), .ckpt_take(ckpt_take), .ckpt_id(ckpt_id),
    .ckpt_full(ckpt_full), .ckpt_free(ckpt_free), .restore_en(restore_en),
    .restore_id(restore_id), .busy(busy)
  );

  typedef struct {int id; int tos; int cnt; logic [W-1:0] top;} ck_t;
  logic [W-1:0] m_mem [DEPTH];
  int m_tos, m_cnt, m_alloc;
  logic m_pv, m_busy;
  logic [W-1:0] m_pa;
  ck_t m_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_tos = DEPTH - 1;
    m_cnt = 0;
    m_pv = 1'b0;
    m_pa = '0;
    m_busy = 1'b0;
    m_alloc = 0;
    m_q.delete();
  endfunction

  function automatic void model_step();
    int pre, k;
    ck_t c;
    bit rs, act;
    rs = restore_en;
    act = !m_busy && !rs;
    pre = m_q.size();
    if (rs && CK) begin
      k = 0;
      for (int i = 0; i < m_q.size(); i++) if (m_q[i].id == int'(restore_id)) k = i;
      c = m_q[k];
      while (m_q.size() > k + 1) void'(m_q.pop_back());
      m_tos = c.tos;
      m_cnt = c.cnt;
      m_mem[c.tos] = c.top;
      m_alloc = (int'(restore_id) + 1) % N;
    end else if (rs) begin
      m_tos = DEPTH - 1;
      m_cnt = 0;
    end else if (CK && act && ckpt_take && pre < N) begin
      m_q.push_back('{m_alloc, m_tos, m_cnt, m_mem[m_tos]});
      m_alloc = (m_alloc + 1) % N;
    end
    if (CK && ckpt_free && pre > 0) void'(m_q.pop_front());
    m_pv = 1'b0;
    if (act) begin
      if (push_en && pop_en) begin
        m_pa = m_mem[m_tos];
        m_pv = m_cnt > 0;
        m_mem[m_tos] = push_addr;
        if (m_cnt == 0) m_cnt = 1;
      end else if (push_en) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_mem[m_tos] = push_addr;
        if (m_cnt < DEPTH) m_cnt++;
      end else if (pop_en && m_cnt > 0) begin
        m_pa = m_mem[m_tos];
        m_pv = 1'b1;
        m_tos = (m_tos + DEPTH - 1) % DEPTH;
        m_cnt--;
      end
    end
    m_busy = rs;
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    check("pred_valid", 64'(pred_valid), 64'(m_pv));
    if (m_pv) check("pred_addr", 64'(pred_addr), 64'(m_pa));
    check("busy", 64'(busy), 64'(m_busy));
    check("ckpt_full", 64'(ckpt_full), 64'(CK && m_q.size() == N));
    check("ckpt_id", 64'(ckpt_id), 64'(m_alloc));
  endtask

  task automatic step(input bit pu, input logic [W-1:0] a, input bit po, input bit tk,
                      input bit fr, input bit rs, input int rid);
    push_en = pu;
    push_addr = a;
    pop_en = po;
    ckpt_take = tk;
    ckpt_free = fr;
    restore_en = rs;
    restore_id = CW'(rid);
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(0, '0, 0, 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  initial begin
    int rid;
    bit rs;
    do_reset();
    check("reset_pa", 64'(pred_addr), 64'h0);
    check("reset_full", 64'(ckpt_full), 64'h0);
    // basic push/pop
    step(1, 'h1000, 0, 0, 0, 0, 0);
    step(1, 'h2000, 0, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0, 0);
    check("basic_a0", 64'(pred_addr), 64'h2000);
    step(0, '0, 1, 0, 0, 0, 0);
    check("basic_a1", 64'(pred_addr), 64'h1000);
    step(0, '0, 1, 0, 0, 0, 0);
    check("basic_empty", 64'(pred_valid), 64'h0);
    // overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) step(1, W'(32'h100 + i), 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, '0, 1, 0, 0, 0, 0);
      check("ovf_valid", 64'(pred_valid), 64'(i < 16));
      if (i < 16) check("ovf_addr", 64'(pred_addr), 64'h110 - 64'(i));
    end
    // replace
    step(1, 'hA0, 0, 0, 0, 0, 0);
    step(1, 'hB0, 1, 0, 0, 0, 0);
    check("rep_v", 64'(pred_valid), 64'h1);
    check("rep_a0", 64'(pred_addr), 64'hA0);
    step(0, '0, 1, 0, 0, 0, 0);
    check("rep_a1", 64'(pred_addr), 64'hB0);
    // checkpoint overwrite repair
    do_reset();
    step(1, 'h10, 0, 0, 0, 0, 0);
    step(1, 'h20, 0, 0, 0, 0, 0);
    check("repair_id", 64'(ckpt_id), 64'h0);
    step(0, '0, 0, 1, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0, 0);
    step(1, 'h99, 0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1, 0);
    check("repair_busy1", 64'(busy), 64'h1);
    step(0, '0, 0, 0, 0, 0, 0);
    check("repair_busy0", 64'(busy), 64'h0);
    step(0, '0, 1, 0, 0, 0, 0);
    check("repair_pv0", 64'(pred_valid), 64'(CK));
    step(0, '0, 1, 0, 0, 0, 0);
    check("repair_pv1", 64'(pred_valid), 64'(CK));
    // checkpoint full and free
    do_reset();
    for (int i = 0; i < 8; i++) step(0, '0, 0, 1, 0, 0, 0);
    check("full8", 64'(ckpt_full), 64'(CK));
    step(0, '0, 0, 1, 0, 0, 0);
    check("full_noadv", 64'(ckpt_id), 64'h0);
    step(0, '0, 0, 0, 1, 0, 0);
    check("free_full", 64'(ckpt_full), 64'h0);
    // reset during restore
    step(0, '0, 0, 0, 0, 1, 3);
    check("rr_busy1", 64'(busy), 64'h1);
    rst = 1'b0;
    step(0, '0, 0, 0, 0, 0, 0);
    check("rr_busy0", 64'(busy), 64'h0);
    check("rr_pv", 64'(pred_valid), 64'h0);
    rst = 1'b1;
    step(0, '0, 1, 0, 0, 0, 0);
    check("rr_pop", 64'(pred_valid), 64'h0);
    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rs = $urandom_range(0, 15) == 0;
      rid = 0;
      if (CK && m_q.size() == 0) rs = 1'b0;
      if (rs && CK) rid = m_q[$urandom_range(0, m_q.size() - 1)].id;
      step($urandom_range(0, 1) == 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rs, rid);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
